// File: rtl/mc_stall_ctrl_pkg.sv
// Shared constants for the pipeline stall controller: stall vector encodings,
// multi-cycle op codes and sequencer state codes.
package mc_stall_ctrl_pkg;

  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

  // Stall bits: {WB, MEM, EX, ID, IF, PC}
  localparam logic [5:0] StallNone   = {6{NoStop}};
  localparam logic [5:0] StallFromId = {NoStop, NoStop, NoStop, Stop, Stop, Stop};
  localparam logic [5:0] StallFromEx = {NoStop, NoStop, Stop, Stop, Stop, Stop};

  localparam logic [1:0] McOpNone = 2'b00;
  localparam logic [1:0] McOpMadd = 2'b01;
  localparam logic [1:0] McOpDiv  = 2'b10;

  typedef enum logic [1:0] {
    McIdle    = 2'd0,
    McMadd2   = 2'd1,
    McDivWait = 2'd2
  } mc_state_t;

  // EX requests freeze everything up to EX and win over an ID request.
  function automatic logic [5:0] merge_stall(input logic ex_req, input logic id_req);
    logic [5:0] s;
    s = StallNone;
    if (ex_req)      s = StallFromEx;
    else if (id_req) s = StallFromId;
    return s;
  endfunction

endpackage

// File: rtl/mc_stall_ctrl_stall_counter.sv
// 32-bit enable counter used to count EX-stalled cycles; wraps naturally.
module stall_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_en,
  output logic [31:0] o_count
);

  logic [31:0] r_count;

  always_ff @(posedge clk) begin
    if (rst)       r_count <= 32'd0;
    else if (i_en) r_count <= r_count + 32'd1;
  end

  assign o_count = r_count;

endmodule

// File: rtl/mc_stall_ctrl.sv
// Stall merge and multi-cycle EX sequencer (madd/msub two-pass, div handshake).
// Optional stalled-cycle counter port enabled by defining STALL_CNT_EN.
module mc_stall_ctrl
  import mc_stall_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_id,
  input  logic [1:0]  ex_mc_op,
  input  logic        div_ready,
  input  logic        flush,
  output logic [5:0]  stall,
  output logic [1:0]  cnt,
  output logic        div_start,
  output logic        div_annul,
  output logic        mc_busy
`ifdef STALL_CNT_EN
  ,
  output logic [31:0] stall_cycles
`endif
);

  mc_state_t  r_state;
  mc_state_t  w_next_state;
  logic       w_ex_req;
  logic [1:0] w_cnt;
  logic       w_div_start;
  logic       w_div_annul;
  logic [5:0] w_stall;

  always_ff @(posedge clk) begin
    if (rst) r_state <= McIdle;
    else     r_state <= w_next_state;
  end

  // Outputs are decoded combinationally so a request stalls in its own cycle.
  always_comb begin
    w_next_state = r_state;
    w_ex_req     = 1'b0;
    w_cnt        = 2'b00;
    w_div_start  = 1'b0;
    w_div_annul  = 1'b0;
    if (rst) begin
      w_next_state = McIdle;
    end else if (flush) begin
      w_next_state = McIdle;
      w_div_annul  = (r_state == McDivWait);
    end else begin
      case (r_state)
        McIdle: begin
          case (ex_mc_op)
            McOpMadd: begin
              w_ex_req     = 1'b1;
              w_next_state = McMadd2;
            end
            McOpDiv: begin
              w_ex_req     = 1'b1;
              w_div_start  = 1'b1;
              w_next_state = McDivWait;
            end
            default: w_next_state = McIdle;
          endcase
        end
        McMadd2: begin
          w_cnt        = 2'b01;
          w_next_state = McIdle;
        end
        McDivWait: begin
          // The ready cycle releases EX; ex_mem captures the quotient at that edge.
          if (div_ready) begin
            w_next_state = McIdle;
          end else begin
            w_ex_req    = 1'b1;
            w_div_start = 1'b1;
          end
        end
        default: w_next_state = McIdle;
      endcase
    end
  end

  always_comb begin
    w_stall = StallNone;
    if (!rst) w_stall = merge_stall(w_ex_req, stallreq_id);
  end

  assign stall     = w_stall;
  assign cnt       = w_cnt;
  assign div_start = w_div_start;
  assign div_annul = w_div_annul;
  assign mc_busy   = !rst && (r_state != McIdle);

`ifdef STALL_CNT_EN
  stall_counter u_stall_counter (
    .clk     (clk),
    .rst     (rst),
    .i_en    (w_stall[3]),
    .o_count (stall_cycles)
  );
`endif

endmodule

// File: tb/tb_mc_stall_ctrl.sv
// Self-checking bench for mc_stall_ctrl: vector table plus multi-cycle divide sequences.
module tb_mc_stall_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       stallreq_id;
  logic [1:0] ex_mc_op;
  logic       div_ready;
  logic       flush;
  logic [5:0] stall;
  logic [1:0] cnt;
  logic       div_start;
  logic       div_annul;
  logic       mc_busy;
`ifdef STALL_CNT_EN
  logic [31:0] stall_cycles;
`endif

  int checks   = 0;
  int failures = 0;

  // {stall[10:5], cnt[4:3], div_start[2], div_annul[1], mc_busy[0]}
  logic [10:0] exp_q[$];
  string       name_q[$];
  logic [31:0] exp_sc;
  logic        sc_valid = 1'b0;

  typedef struct {
    string      name;
    logic       r;
    logic       id;
    logic [1:0] op;
    logic       rdy;
    logic       fl;
    logic [5:0] e_stall;
    logic [1:0] e_cnt;
    logic       e_ds;
    logic       e_an;
    logic       e_busy;
  } vec_t;

  vec_t vecs[$];

  localparam logic [5:0] S_NONE = 6'b000000;
  localparam logic [5:0] S_ID   = 6'b000111;
  localparam logic [5:0] S_EX   = 6'b001111;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  mc_stall_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .stallreq_id  (stallreq_id),
    .ex_mc_op     (ex_mc_op),
    .div_ready    (div_ready),
    .flush        (flush),
    .stall        (stall),
    .cnt          (cnt),
    .div_start    (div_start),
    .div_annul    (div_annul),
    .mc_busy      (mc_busy)
`ifdef STALL_CNT_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  // ---------------- scoreboard ----------------
  task automatic check_outputs();
    logic [10:0] got;
    logic [10:0] exp;
    string       nm;
    got = {stall, cnt, div_start, div_annul, mc_busy};
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_empty got=%b", got);
      return;
    end
    exp = exp_q.pop_front();
    nm  = name_q.pop_front();
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got stall=%b cnt=%b ds=%b an=%b busy=%b exp stall=%b cnt=%b ds=%b an=%b busy=%b",
               nm, got[10:5], got[4:3], got[2], got[1], got[0],
               exp[10:5], exp[4:3], exp[2], exp[1], exp[0]);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input string nm, input logic r, input logic id, input logic [1:0] op,
                       input logic rdy, input logic fl, input logic [5:0] e_stall,
                       input logic [1:0] e_cnt, input logic e_ds, input logic e_an,
                       input logic e_busy);
    @(negedge clk);
    rst         = r;
    stallreq_id = id;
    ex_mc_op    = op;
    div_ready   = rdy;
    flush       = fl;
    exp_q.push_back({e_stall, e_cnt, e_ds, e_an, e_busy});
    name_q.push_back(nm);
    #1;
    check_outputs();
`ifdef STALL_CNT_EN
    if (sc_valid) begin
      checks++;
      if (stall_cycles !== exp_sc) begin
        failures++;
        $display("FAIL stall_cycles at %s got=%0d exp=%0d", nm, stall_cycles, exp_sc);
      end
    end
`endif
    // Counter model advances at the coming rising edge.
    if (r) begin
      exp_sc   = 32'd0;
      sc_valid = 1'b1;
    end else if (e_stall[3]) begin
      exp_sc = exp_sc + 32'd1;
    end
  endtask

  task automatic add_vec(input string nm, input logic r, input logic id, input logic [1:0] op,
                         input logic rdy, input logic fl, input logic [5:0] e_stall,
                         input logic [1:0] e_cnt, input logic e_ds, input logic e_an,
                         input logic e_busy);
    vec_t v;
    v.name = nm; v.r = r; v.id = id; v.op = op; v.rdy = rdy; v.fl = fl;
    v.e_stall = e_stall; v.e_cnt = e_cnt; v.e_ds = e_ds; v.e_an = e_an; v.e_busy = e_busy;
    vecs.push_back(v);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int k;
    logic id;
    rst = 1'b1; stallreq_id = 1'b0; ex_mc_op = 2'b00; div_ready = 1'b0; flush = 1'b0;
    exp_sc = 32'd0;

    //       name           r  id op     rdy fl  stall   cnt    ds an busy
    add_vec("reset_a",      1, 0, 2'b01, 0, 0, S_NONE, 2'b00, 0, 0, 0);
    add_vec("reset_b",      1, 0, 2'b01, 0, 0, S_NONE, 2'b00, 0, 0, 0);
    add_vec("madd_first",   0, 0, 2'b01, 0, 0, S_EX,   2'b00, 0, 0, 0);
    add_vec("madd_second",  0, 0, 2'b00, 0, 0, S_NONE, 2'b01, 0, 0, 1);
    add_vec("idle",         0, 0, 2'b00, 0, 0, S_NONE, 2'b00, 0, 0, 0);
    add_vec("id_only",      0, 1, 2'b00, 0, 0, S_ID,   2'b00, 0, 0, 0);
    add_vec("reserved",     0, 0, 2'b11, 0, 0, S_NONE, 2'b00, 0, 0, 0);
    add_vec("reserved_id",  0, 1, 2'b11, 0, 0, S_ID,   2'b00, 0, 0, 0);
    add_vec("rdy_in_idle",  0, 0, 2'b00, 1, 0, S_NONE, 2'b00, 0, 0, 0);
    add_vec("b2b_madd",     0, 0, 2'b01, 0, 0, S_EX,   2'b00, 0, 0, 0);
    add_vec("b2b_madd2",    0, 0, 2'b10, 0, 0, S_NONE, 2'b01, 0, 0, 1);
    add_vec("b2b_div",      0, 0, 2'b10, 0, 0, S_EX,   2'b00, 1, 0, 0);
    add_vec("div_wait_id",  0, 1, 2'b10, 0, 0, S_EX,   2'b00, 1, 0, 1);
    add_vec("div_ready_id", 0, 1, 2'b10, 1, 0, S_ID,   2'b00, 0, 0, 1);
    add_vec("after_div",    0, 0, 2'b00, 0, 0, S_NONE, 2'b00, 0, 0, 0);
    add_vec("madd_r",       0, 0, 2'b01, 0, 0, S_EX,   2'b00, 0, 0, 0);
    add_vec("madd2_rdy",    0, 0, 2'b00, 1, 0, S_NONE, 2'b01, 0, 0, 1);
    add_vec("idle_r",       0, 0, 2'b00, 0, 0, S_NONE, 2'b00, 0, 0, 0);
    add_vec("flush_idle",   0, 1, 2'b01, 0, 1, S_ID,   2'b00, 0, 0, 0);
    add_vec("post_fl_idle", 0, 0, 2'b00, 0, 0, S_NONE, 2'b00, 0, 0, 0);
    add_vec("madd_f",       0, 0, 2'b01, 0, 0, S_EX,   2'b00, 0, 0, 0);
    add_vec("flush_madd2",  0, 0, 2'b00, 0, 1, S_NONE, 2'b00, 0, 0, 1);
    add_vec("post_fl_madd", 0, 0, 2'b00, 0, 0, S_NONE, 2'b00, 0, 0, 0);
    add_vec("div_fr",       0, 0, 2'b10, 0, 0, S_EX,   2'b00, 1, 0, 0);
    add_vec("flush_and_rdy",0, 0, 2'b00, 1, 1, S_NONE, 2'b00, 0, 1, 1);
    add_vec("post_fr",      0, 0, 2'b00, 1, 0, S_NONE, 2'b00, 0, 0, 0);
    add_vec("div_rs",       0, 0, 2'b10, 0, 0, S_EX,   2'b00, 1, 0, 0);
    add_vec("div_rs_wait",  0, 0, 2'b10, 0, 0, S_EX,   2'b00, 1, 0, 1);
    add_vec("rst_mid_div",  1, 1, 2'b10, 0, 0, S_NONE, 2'b00, 0, 0, 0);
    add_vec("post_rst",     0, 0, 2'b00, 0, 0, S_NONE, 2'b00, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++)
      drive(vecs[i].name, vecs[i].r, vecs[i].id, vecs[i].op, vecs[i].rdy, vecs[i].fl,
            vecs[i].e_stall, vecs[i].e_cnt, vecs[i].e_ds, vecs[i].e_an, vecs[i].e_busy);

    // Divide with ready 33 cycles after start: 33 stalled cycles, then release.
    drive("div33_start", 0, 0, 2'b10, 0, 0, S_EX, 2'b00, 1, 0, 0);
    for (int i = 0; i < 32; i++)
      drive("div33_wait", 0, 0, 2'b00, 0, 0, S_EX, 2'b00, 1, 0, 1);
    drive("div33_ready", 0, 0, 2'b00, 1, 0, S_NONE, 2'b00, 0, 0, 1);
    drive("div33_idle",  0, 0, 2'b00, 0, 0, S_NONE, 2'b00, 0, 0, 0);

    // Flush on the fifth cycle of a divide; the late ready must be ignored.
    drive("divfl_start", 0, 0, 2'b10, 0, 0, S_EX, 2'b00, 1, 0, 0);
    for (int i = 0; i < 3; i++)
      drive("divfl_wait", 0, 0, 2'b00, 0, 0, S_EX, 2'b00, 1, 0, 1);
    id = 1'($urandom_range(0, 1));
    drive("divfl_flush", 0, id, 2'b00, 0, 1, id ? S_ID : S_NONE, 2'b00, 0, 1, 1);
    drive("divfl_late_rdy", 0, 0, 2'b00, 1, 0, S_NONE, 2'b00, 0, 0, 0);
    drive("divfl_idle",     0, 0, 2'b00, 0, 0, S_NONE, 2'b00, 0, 0, 0);

    // Random-length divides with random ID stall requests, each followed by a madd.
    for (int n = 0; n < 6; n++) begin
      k = $urandom_range(1, 12);
      drive("rnd_div_start", 0, 1'($urandom_range(0, 1)), 2'b10, 0, 0, S_EX, 2'b00, 1, 0, 0);
      for (int i = 1; i < k; i++)
        drive("rnd_div_wait", 0, 1'($urandom_range(0, 1)), 2'b10, 0, 0, S_EX, 2'b00, 1, 0, 1);
      id = 1'($urandom_range(0, 1));
      drive("rnd_div_ready", 0, id, 2'b10, 1, 0, id ? S_ID : S_NONE, 2'b00, 0, 0, 1);
      drive("rnd_madd",  0, 0, 2'b01, 0, 0, S_EX,   2'b00, 0, 0, 0);
      id = 1'($urandom_range(0, 1));
      drive("rnd_madd2", 0, id, 2'b00, 0, 0, id ? S_ID : S_NONE, 2'b01, 0, 0, 1);
    end
    drive("final_idle", 0, 0, 2'b00, 0, 0, S_NONE, 2'b00, 0, 0, 0);

    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
    end

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mc_stall_ctrl.md
# mc_stall_ctrl

Pipeline stall controller and multi-cycle EX sequencer for the 5-stage MIPS core. It merges stall requests from ID and EX into the 6-bit `stall` vector consumed by pc_reg, if_id, id_ex, ex_mem and mem_wb. It also sequences the multi-cycle HI/LO operations: madd/msub (two passes through EX) and div (handshake with the iterative divider). The `cnt` step index drives the EX accumulate path, which round-trips through ex_mem.

## Interface
Parameters: none. Widths come from `defines.v`.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge
- `rst`  in  1  reset, synchronous, active-high (`RstEnable` = 1'b1)
- `stallreq_id`  in  1  load-use stall request from ID
- `ex_mc_op`  in  2  multi-cycle op in EX: 00 none, 01 madd/msub, 10 div, 11 reserved (treated as 00)
- `div_ready`  in  1  divider result valid (one-cycle pulse)
- `flush`  in  1  abort the in-flight multi-cycle op
- `stall`  out  6  bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 = `Stop`
- `cnt`  out  2  EX step index for madd/msub
- `div_start`  out  1  start/hold request to the divider
- `div_annul`  out  1  cancel the divider operation
- `mc_busy`  out  1  state is not IDLE
- `stall_cycles`  out  32  stalled-cycle counter (only with `STALL_CNT_EN`)

## Operation
FSM states are IDLE, MADD2 and DIV_WAIT. The state is registered. All outputs are combinational from state and inputs in the same cycle.

Stall encodings:
- ex_req → 6'b001111
- id_req → 6'b000111
- none → 6'b000000
- ex_req takes priority over id_req.

IDLE:
- op 01: ex_req=1, cnt=00, next state MADD2.
- op 10: ex_req=1, div_start=1, next state DIV_WAIT.
- Otherwise: no EX request; stall = id_req if `stallreq_id`, else none.

MADD2:
- cnt=01, ex_req=0. The instruction advances at the next edge.
- Next state IDLE, unconditionally.

DIV_WAIT:
- div_start=1 and ex_req=1 until `div_ready` is seen.
- Cycle with `div_ready`=1: div_start=0, ex_req=0, next state IDLE. The result is captured by ex_mem at that edge.
- `ex_mc_op` is ignored in this state.

flush (any state):
- Next state IDLE.
- Same cycle: ex_req=0, cnt=00, div_start=0. `stall` still reflects `stallreq_id`.
- div_annul=1 only when flush is asserted while in DIV_WAIT.

rst:
- Next state IDLE.
- While rst=1, all outputs are forced to 0 (`stall`=0, `cnt`=00, `div_start`=0, `div_annul`=0, `mc_busy`=0).

Reserved op 11: no stall, no state change.

## Timing
- Latency from request to stall is zero: `stall` is valid in the same cycle as the `ex_mc_op` or `stallreq_id` that caused it.
- madd/msub occupies exactly 2 EX cycles: cycle N stall=001111, cnt=00; cycle N+1 stall=000000, cnt=01.
- div occupies K+1 EX cycles when `div_ready` arrives K cycles after the start cycle. div_start is high for exactly those stalled cycles.
- Back-to-back ops: the new instruction appears in EX in the cycle after release and is accepted from IDLE. There is no dead cycle.
- `div_ready` while in IDLE or MADD2 is ignored.
- `div_ready` and `flush` in the same cycle: flush wins, div_annul=1.
- rst asserted mid-divide: state returns to IDLE at that edge; div_annul is not asserted (the divider resets itself).

## Configuration
- `STALL_CNT_EN` defined:
  - The `stall_cycles` port exists.
  - The counter increments on each edge where `stall[3]`=1, wraps at 2^32-1 → 0, and clears on rst.
- `STALL_CNT_EN` undefined:
  - The port and the counter logic are absent.
  - All other behaviour is identical.

## Structure
- Constants added to `defines.v`:
  - stall encodings `StallNone`, `StallFromId`, `StallFromEx`
  - op codes `McOpNone`, `McOpMadd`, `McOpDiv`
  - state codes `McIdle`, `McMadd2`, `McDivWait`
  - reuse the existing `Stop`/`NoStop`
- Sub-module `stall_counter` (32-bit enable counter), instantiated only under `STALL_CNT_EN`.

## Test plan
- rst=1 for 2 cycles with `ex_mc_op`=01 → `stall`=0, `cnt`=0, `mc_busy`=0. After release: IDLE, and the op is accepted on the first cycle.
- `ex_mc_op`=01 once → `stall` sequence 001111, 000000; `cnt` sequence 00, 01; `mc_busy` sequence 0, 1, 0.
- `ex_mc_op`=10, `div_ready` pulsed 33 cycles later → div_start high 33 cycles, stall=001111 for 33 cycles, then 000000 on the ready cycle; `stall_cycles` +33.
- `stallreq_id`=1 during DIV_WAIT → stall=001111; the same cycle in IDLE with op 00 → 000111.
- `flush` on cycle 5 of a divide → div_annul=1 and div_start=0 that cycle; IDLE next cycle; a later `div_ready` is ignored.
- madd then div back-to-back → stall 001111, 000000, 001111…; no lost or duplicated `cnt`=01 cycle.
